// File: rtl/chunk_xform_sched_pkg.sv
//------------------------------------------------------------------------------
// Module  : chunk_xform_sched_pkg
// Brief   : Mode and FSM state encodings shared by the scheduler and its bench.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package chunk_xform_sched_pkg;

  typedef enum logic [1:0] {
    MODE_PASS      = 2'd0,
    MODE_INVERT    = 2'd1,
    MODE_BITREV    = 2'd2,
    MODE_CHUNK_REV = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/chunk_xform.sv
//------------------------------------------------------------------------------
// Module  : chunk_xform
// Brief   : Combinational per-chunk transform (pass, invert, bit reverse).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module chunk_xform
  import chunk_xform_sched_pkg::*;
#(
  parameter int CHUNK_SIZE = 8
) (
  input  mode_t                 mode,
  input  logic [CHUNK_SIZE-1:0] chunk_in,
  output logic [CHUNK_SIZE-1:0] chunk_out
);

  logic [CHUNK_SIZE-1:0] w_rev;

  for (genvar b = 0; b < CHUNK_SIZE; b++) begin : g_bitrev
    assign w_rev[b] = chunk_in[CHUNK_SIZE-1-b];
  end

  // Chunk reordering is handled by the parent, so that mode passes through here.
  always_comb begin
    chunk_out = chunk_in;
    case (mode)
      MODE_INVERT: chunk_out = ~chunk_in;
      MODE_BITREV: chunk_out = w_rev;
      default:     chunk_out = chunk_in;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/chunk_xform_sched.sv
//------------------------------------------------------------------------------
// Module  : chunk_xform_sched
// Brief   : Accepts a word, transforms it one chunk per cycle, then hands it off.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module chunk_xform_sched
  import chunk_xform_sched_pkg::*;
#(
  parameter int CHUNKS     = 4,
  parameter int CHUNK_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHUNKS*CHUNK_SIZE-1:0] in_data,
  input  logic [1:0]                   in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHUNKS*CHUNK_SIZE-1:0] out_data,
  output logic                         busy
);

  localparam int c_idx_w = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int c_w     = CHUNKS * CHUNK_SIZE;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CHUNKS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_w-1:0]       r_word;
  mode_t                r_mode;
  logic [c_w-1:0]       r_out_data;
  logic [c_w-1:0]       w_out_nxt;
  logic [c_idx_w-1:0]   w_src_idx;
  logic [CHUNK_SIZE-1:0] w_src_chunks [CHUNKS];
  logic [CHUNK_SIZE-1:0] w_src;
  logic [CHUNK_SIZE-1:0] w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)              w_state_nxt = ST_RUN;
      ST_RUN:  if (r_idx == c_last_idx)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)             w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < CHUNKS; i++) begin : g_unpack
    assign w_src_chunks[i] = r_word[i*CHUNK_SIZE +: CHUNK_SIZE];
  end

  // Chunk reversal only changes which source chunk feeds the current slot.
  assign w_src_idx = (r_mode == MODE_CHUNK_REV) ? (c_last_idx - r_idx) : r_idx;
  assign w_src     = w_src_chunks[w_src_idx];

  chunk_xform #(
    .CHUNK_SIZE (CHUNK_SIZE)
  ) u_chunk_xform (
    .mode      (r_mode),
    .chunk_in  (w_src),
    .chunk_out (w_res)
  );

  for (genvar i = 0; i < CHUNKS; i++) begin : g_merge
    assign w_out_nxt[i*CHUNK_SIZE +: CHUNK_SIZE] =
      (r_idx == c_idx_w'(i)) ? w_res : r_out_data[i*CHUNK_SIZE +: CHUNK_SIZE];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_word     <= '0;
      r_mode     <= MODE_PASS;
      r_out_data <= '0;
    end else begin
      if (r_state == ST_IDLE && in_valid) begin
        r_word <= in_data;
        r_mode <= mode_t'(in_mode);
        r_idx  <= '0;
      end
      if (r_state == ST_RUN) begin
        r_out_data <= w_out_nxt;
        if (r_idx != c_last_idx) r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_chunk_xform_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_chunk_xform_sched
// Brief   : Directed vector bench for chunk_xform_sched (4 chunks of 8 bits).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_chunk_xform_sched;
  import chunk_xform_sched_pkg::*;

  localparam int c_chunks = 4;
  localparam int c_cs     = 8;
  localparam int c_w      = c_chunks * c_cs;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [c_w-1:0] in_data;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [c_w-1:0] out_data;
  logic           busy;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [1:0]     mode;
    logic [c_w-1:0] data;
    logic [c_w-1:0] expect_data;
    int             hold;
  } vec_t;

  vec_t vecs [8];

  chunk_xform_sched #(
    .CHUNKS     (c_chunks),
    .CHUNK_SIZE (c_cs)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [c_w-1:0] act, input logic [c_w-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction: accept, scramble inputs during RUN, measure latency, optional backpressure.
  task automatic run_op(input vec_t v, input int k);
    int lat;
    bit ready_ok;
    logic [c_w-1:0] held;
    out_ready = (v.hold == 0);
    @(negedge clk);
    check($sformatf("v%0d in_ready idle", k), {31'd0, in_ready}, 1);
    in_valid = 1'b1;
    in_data  = v.data;
    in_mode  = v.mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~v.data ^ c_w'($urandom);
    in_mode  = ~v.mode;
    check($sformatf("v%0d busy after accept", k), {31'd0, busy}, 1);
    lat = 0;
    ready_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) ready_ok = 1'b0;
    end
    check($sformatf("v%0d latency", k), c_w'(lat), 4);
    check($sformatf("v%0d in_ready low in run", k), {31'd0, ready_ok}, 1);
    check($sformatf("v%0d out_data", k), out_data, v.expect_data);
    if (v.hold > 0) begin
      held = out_data;
      for (int c = 0; c < v.hold; c++) begin
        @(posedge clk);
        #1;
        check($sformatf("v%0d hold%0d valid", k, c), {31'd0, out_valid}, 1);
        check($sformatf("v%0d hold%0d data", k, c), out_data, held);
        check($sformatf("v%0d hold%0d in_ready", k, c), {31'd0, in_ready}, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d idle after handoff", k), {30'd0, busy, out_valid}, 0);
    check($sformatf("v%0d out_data kept", k), out_data, v.expect_data);
    out_ready = 1'b0;
  endtask

  initial begin
    int edges;
    int acc2;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    out_ready = 1'b0;

    vecs[0] = '{2'(MODE_INVERT),    32'h12345678, 32'hEDCBA987, 0};
    vecs[1] = '{2'(MODE_BITREV),    32'h01800F80, 32'h8001F001, 0};
    vecs[2] = '{2'(MODE_CHUNK_REV), 32'h11223344, 32'h44332211, 0};
    vecs[3] = '{2'(MODE_PASS),      32'hA5A5F00F, 32'hA5A5F00F, 0};
    vecs[4] = '{2'(MODE_INVERT),    32'h00FF55AA, 32'hFF00AA55, 5};
    vecs[5] = '{2'(MODE_BITREV),    32'h12345678, 32'h482C6A1E, 0};
    vecs[6] = '{2'(MODE_CHUNK_REV), 32'h000000FF, 32'hFF000000, 2};
    vecs[7] = '{2'(MODE_PASS),      32'h00000000, 32'h00000000, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset out_data", out_data, 0);
    check("reset valid/busy", {30'd0, out_valid, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", {31'd0, in_ready}, 1);

    for (int k = 0; k < 8; k++) run_op(vecs[k], k);

    // Back-to-back: in_valid held high, second acceptance must wait one idle cycle.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11223344;
    in_mode   = 2'(MODE_CHUNK_REV);
    @(posedge clk);
    #1;
    in_data = 32'hA5A5F00F;
    in_mode = 2'(MODE_PASS);
    repeat (4) @(posedge clk);
    #1;
    check("b2b first valid", {31'd0, out_valid}, 1);
    check("b2b first data", out_data, 32'h44332211);
    @(posedge clk);
    #1;
    check("b2b gap idle", {30'd0, busy, in_ready}, 1);
    acc2 = 0;
    edges = 0;
    while (!busy && edges < 5) begin
      @(posedge clk);
      #1;
      edges++;
    end
    acc2 = edges;
    check("b2b gap edges", c_w'(acc2), 1);
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("b2b second latency", c_w'(edges), 4);
    check("b2b second data", out_data, 32'hA5A5F00F);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset during RUN after two chunk edges.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    in_mode  = 2'(MODE_INVERT);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst mid out_data", out_data, 0);
    check("rst mid valid/busy", {30'd0, out_valid, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst mid in_ready", {31'd0, in_ready}, 1);
    edges = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) edges++;
    end
    check("rst mid no stray valid", c_w'(edges), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
